// File: rtl/serial_xs3_bcd_codec.sv
// Serial LSB-first Excess-3 <-> BCD converter with per-digit code checking
// and parallel assembly of a DIGITS-wide converted word.
module serial_xs3_bcd_codec #(
  parameter int DIGITS = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  X,
  input  logic                  En,
  input  logic                  Mode,
  output logic                  Z,
  output logic                  DigitDone,
  output logic                  DigitErr,
  output logic                  WordDone,
  output logic                  WordErr,
  output logic [4*DIGITS-1:0]   Dout
);
  localparam int W  = 4 * DIGITS;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0]    K      = 4'b0011;
  localparam logic [DW-1:0] D_LAST = DW'(DIGITS - 1);

  logic [1:0]    b_reg, b_next;
  logic [DW-1:0] d_reg, d_next;
  logic          c_reg, c_next;
  logic          m_reg, m_next;
  // Only the three previous bits are kept; the fourth is the live X.
  logic [2:0]    in_sh_reg, in_sh_next;
  logic [W-2:0]  out_sh_reg, out_sh_next;
  logic [W-1:0]  dout_reg, dout_next;
  logic          digit_done_reg, digit_done_next;
  logic          digit_err_reg, digit_err_next;
  logic          word_done_reg, word_done_next;
  logic          word_err_reg, word_err_next;
  logic          err_acc_reg, err_acc_next;

  logic       word_start, mode_eff, c_eff, k, z_raw;
  logic       last_bit, last_digit, code_err, err_base;
  logic       borrow, carry;
  logic [3:0] code;

  assign word_start = (b_reg == 2'd0) && (d_reg == '0);
  assign mode_eff   = word_start ? Mode : m_reg;
  assign c_eff      = (b_reg == 2'd0) ? 1'b0 : c_reg;
  assign k          = K[b_reg];
  assign z_raw      = X ^ k ^ c_eff;
  assign borrow     = (~X & (k | c_eff)) | (k & c_eff);
  assign carry      = (X & k) | (X & c_eff) | (k & c_eff);
  assign last_bit   = (b_reg == 2'd3);
  assign last_digit = (d_reg == D_LAST);
  assign code       = {X, in_sh_reg};
  assign code_err   = mode_eff ? (code > 4'd9) : ((code < 4'd3) || (code > 4'd12));
  assign err_base   = word_start ? 1'b0 : err_acc_reg;

  always_comb begin
    b_next          = b_reg;
    d_next          = d_reg;
    c_next          = c_reg;
    m_next          = m_reg;
    in_sh_next      = in_sh_reg;
    out_sh_next     = out_sh_reg;
    dout_next       = dout_reg;
    word_err_next   = word_err_reg;
    err_acc_next    = err_acc_reg;
    digit_done_next = 1'b0;
    digit_err_next  = 1'b0;
    word_done_next  = 1'b0;
    if (En) begin
      b_next       = b_reg + 2'd1;
      c_next       = mode_eff ? carry : borrow;
      m_next       = mode_eff;
      in_sh_next   = {X, in_sh_reg[2:1]};
      out_sh_next  = (W > 2) ? {z_raw, out_sh_reg[W-2:1]} : (W-1)'(z_raw);
      err_acc_next = err_base | (last_bit & code_err);
      if (last_bit) begin
        d_next          = last_digit ? '0 : d_reg + DW'(1);
        digit_done_next = 1'b1;
        digit_err_next  = code_err;
        if (last_digit) begin
          word_done_next = 1'b1;
          dout_next      = {z_raw, out_sh_reg};
          word_err_next  = err_base | code_err;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      b_reg          <= '0;
      d_reg          <= '0;
      c_reg          <= 1'b0;
      m_reg          <= 1'b0;
      in_sh_reg      <= '0;
      out_sh_reg     <= '0;
      dout_reg       <= '0;
      digit_done_reg <= 1'b0;
      digit_err_reg  <= 1'b0;
      word_done_reg  <= 1'b0;
      word_err_reg   <= 1'b0;
      err_acc_reg    <= 1'b0;
    end else begin
      b_reg          <= b_next;
      d_reg          <= d_next;
      c_reg          <= c_next;
      m_reg          <= m_next;
      in_sh_reg      <= in_sh_next;
      out_sh_reg     <= out_sh_next;
      dout_reg       <= dout_next;
      digit_done_reg <= digit_done_next;
      digit_err_reg  <= digit_err_next;
      word_done_reg  <= word_done_next;
      word_err_reg   <= word_err_next;
      err_acc_reg    <= err_acc_next;
    end
  end

  assign Z         = Rst ? 1'b0 : z_raw;
  assign DigitDone = digit_done_reg;
  assign DigitErr  = digit_err_reg;
  assign WordDone  = word_done_reg;
  assign WordErr   = word_err_reg;
  assign Dout      = dout_reg;
endmodule

// File: tb/tb_serial_xs3_bcd_codec.sv
// Directed bench for serial_xs3_bcd_codec: a 4-digit instance driven through a
// scoreboard of expected digit/word results, plus a 1-digit instance.
module tb_serial_xs3_bcd_codec;
  logic clk = 1'b0;
  logic rst, x, en, mode;
  logic z, digit_done, digit_err, word_done, word_err;
  logic [15:0] dout;
  logic x1, en1, mode1;
  logic z1, digit_done1, digit_err1, word_done1, word_err1;
  logic [3:0] dout1;

  int tests = 0;
  int fails = 0;

  logic        digit_q[$];
  logic [15:0] dout_q[$];
  logic        werr_q[$];

  serial_xs3_bcd_codec #(.DIGITS(4)) dut4 (
    .Clk(clk), .Rst(rst), .X(x), .En(en), .Mode(mode), .Z(z),
    .DigitDone(digit_done), .DigitErr(digit_err), .WordDone(word_done),
    .WordErr(word_err), .Dout(dout)
  );

  serial_xs3_bcd_codec #(.DIGITS(1)) dut1 (
    .Clk(clk), .Rst(rst), .X(x1), .En(en1), .Mode(mode1), .Z(z1),
    .DigitDone(digit_done1), .DigitErr(digit_err1), .WordDone(word_done1),
    .WordErr(word_err1), .Dout(dout1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] convert(input logic [3:0] code, input logic m);
    return m ? code + 4'd3 : code - 4'd3;
  endfunction

  function automatic logic is_invalid(input logic [3:0] code, input logic m);
    return m ? (code > 4'd9) : (code < 4'd3 || code > 4'd12);
  endfunction

  // Word/digit results are checked here as the DUT reports them.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (digit_done === 1'b1) begin
        if (digit_q.size() == 0) check("digit_unexpected", 1, 0);
        else check("digit_err", digit_err, digit_q.pop_front());
      end
      if (word_done === 1'b1) begin
        if (dout_q.size() == 0) check("word_unexpected", 1, 0);
        else begin
          check("dout", dout, dout_q.pop_front());
          check("word_err", word_err, werr_q.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b0;
      x = 1'($urandom);
      mode = 1'($urandom);
    end
  endtask

  task automatic drive_bit(input logic xb, input logic mb, input logic zexp);
    @(negedge clk);
    x = xb; en = 1'b1; mode = mb;
    #1 check("z", z, zexp);
  endtask

  task automatic send_digit(input logic [3:0] code, input logic wmode, input logic pin,
                            input int nbits, input int gap_max);
    logic [3:0] e;
    e = convert(code, wmode);
    if (nbits == 4) digit_q.push_back(is_invalid(code, wmode));
    for (int i = 0; i < nbits; i++) begin
      idle($urandom_range(0, gap_max));
      drive_bit(code[i], pin, e[i]);
    end
  endtask

  task automatic send_word(input logic [15:0] codes, input logic wmode,
                           input logic toggle, input int gap_max);
    logic [15:0] e;
    logic        err;
    err = 1'b0;
    for (int dg = 0; dg < 4; dg++) begin
      e[4*dg +: 4] = convert(codes[4*dg +: 4], wmode);
      err = err | is_invalid(codes[4*dg +: 4], wmode);
    end
    dout_q.push_back(e);
    werr_q.push_back(err);
    for (int dg = 0; dg < 4; dg++)
      send_digit(codes[4*dg +: 4], wmode, (toggle && dg >= 2) ? ~wmode : wmode, 4, gap_max);
    idle(2);
  endtask

  task automatic send1(input logic [3:0] code, input logic m);
    logic [3:0] e;
    e = convert(code, m);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      x1 = code[i]; en1 = 1'b1; mode1 = m;
      #1 check("z1", z1, e[i]);
    end
    @(negedge clk);
    en1 = 1'b0;
    check("digit_done1", digit_done1, 1);
    check("word_done1", word_done1, 1);
    check("digit_err1", digit_err1, is_invalid(code, m));
    check("word_err1", word_err1, is_invalid(code, m));
    check("dout1", dout1, e);
    @(negedge clk);
    check("digit_done1_drop", digit_done1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; x = 1'b0; mode = 1'b0;
    en1 = 1'b0; x1 = 1'b0; mode1 = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("z_in_reset", z, 0);
    check("reset_dout", dout, 0);
    check("reset_flags", {digit_done, digit_err, word_done, word_err}, 0);
    check("reset_dout1", dout1, 0);
    @(negedge clk);
    rst = 1'b0;

    send_word(16'h4C38, 1'b0, 1'b0, 0);   // 8,3,12,4 -> 5,0,9,1
    check("word_done_drop", word_done, 0);
    send_word(16'h7651, 1'b0, 1'b0, 0);   // 0001 invalid in digit 0
    send_word(16'h2DC3, 1'b0, 1'b0, 1);   // boundaries 3,12 valid; 13,2 invalid
    send_word(16'h4567, 1'b0, 1'b0, 2);   // -> 1234 with En gaps, error cleared
    send_word(16'h3509, 1'b1, 1'b0, 1);   // BCD 9,0,5,3 -> C,3,8,6
    send_word(16'h1234, 1'b1, 1'b1, 1);   // Mode flips at digit 2: ignored
    send_word(16'h4567, 1'b0, 1'b0, 0);   // new Mode now applies
    send_word(16'h0F9A, 1'b1, 1'b0, 0);   // 10 and 15 invalid in mode 1

    // Reset in the middle of digit 1, after its bit 2.
    send_digit(4'b1000, 1'b0, 1'b0, 4, 0);
    send_digit(4'b0101, 1'b0, 1'b0, 3, 0);
    @(negedge clk);
    rst = 1'b1; en = 1'b1; x = 1'b0;
    #1 check("z_forced_by_rst", z, 0);
    @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_flags", {digit_done, digit_err, word_done, word_err}, 0);
    rst = 1'b0; en = 1'b0;
    send_word(16'h4567, 1'b0, 1'b0, 1);

    send1(4'b1001, 1'b1);                 // BCD 9 -> C
    send1(4'b0001, 1'b0);                 // invalid Excess-3
    send1(4'b1000, 1'b0);                 // 8 -> 5, error cleared

    idle(3);
    check("digit_q_drained", digit_q.size(), 0);
    check("word_q_drained", dout_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
